// File: rtl/lcd_temp_pkg.sv
// Shared constants and types for the LM35/ADC0804 temperature front end and the LCD controller.
package lcd_temp_pkg;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned SAT_MAX    = 9999;

    typedef enum logic [2:0] {
        StStart,
        StWaitIntr,
        StRead,
        StScale,
        StConvert,
        StDone,
        StGap
    } adc_state_e;

    // Double-dabble correction: add 3 to every digit that would overflow on the next shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, BIN_W steps after i_start.
module bin2bcd_seq
    import lcd_temp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int unsigned CNT_W = $clog2(BIN_W);

    logic [BIN_W-1:0]       r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shift;

    always_comb begin
        w_adj   = bcd_add3(r_bcd);
        w_shift = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bin <= w_shift[BIN_W-1:0];
            r_bcd <= w_shift[BCD_W+BIN_W-1:BIN_W];
            if (r_cnt == CNT_W'(BIN_W - 1)) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // o_bcd is the post-shift value, so it holds the final result in the o_done cycle.
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(BIN_W - 1));
    assign o_bcd  = w_shift[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/adc0804_temp_bcd.sv
// Free-running ADC0804 sampler: scales LM35 readings to centi-degrees C and emits packed BCD XX.XX.
module adc0804_temp_bcd
    import lcd_temp_pkg::*;
#(
    parameter int unsigned WR_CYCLES      = 4,
    parameter int unsigned RD_CYCLES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES     = 100000,
    parameter int unsigned CENTI_PER_LSB  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       adc_data,
    input  logic             adc_intr_n,
    output logic             adc_cs_n,
    output logic             adc_wr_n,
    output logic             adc_rd_n,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             timeout_err
);

    localparam int unsigned MAX_A   = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int unsigned MAX_B   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    adc_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_intr_meta, r_intr_sync;
    logic [7:0]       r_data;
    logic             r_adc_cs_n, r_adc_wr_n, r_adc_rd_n;
    logic             w_cs_n_d, w_wr_n_d, w_rd_n_d;
    logic [BCD_W-1:0] r_bcd;
    logic             r_bcd_valid, r_timeout_err;
    logic             w_timeout;
    logic [14:0]      w_prod;
    logic [BIN_W-1:0] w_bin;
    logic             w_conv_start, w_conv_busy, w_conv_done;
    logic [BCD_W-1:0] w_conv_bcd;

    always_comb begin
        w_prod = 15'(r_data) * 15'(CENTI_PER_LSB);
        w_bin  = (w_prod > 15'(SAT_MAX)) ? BIN_W'(SAT_MAX) : w_prod[BIN_W-1:0];
    end

    assign w_conv_start = (r_state == StScale) && !w_conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_conv_start),
        .i_bin   (w_bin),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + CNT_W'(1);
        w_timeout = 1'b0;
        unique case (r_state)
            StStart: begin
                // wr_n still high means the strobe starts on this edge (first cycle after reset)
                if (r_adc_wr_n) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CNT_W'(WR_CYCLES - 1)) begin
                    w_state_d = StWaitIntr;
                    w_cnt_d   = '0;
                end
            end
            StWaitIntr: begin
                if (!r_intr_sync) begin
                    w_state_d = StRead;
                    w_cnt_d   = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_d = StGap;
                    w_cnt_d   = '0;
                    w_timeout = 1'b1;
                end
            end
            StRead: begin
                if (r_cnt == CNT_W'(RD_CYCLES - 1)) begin
                    w_state_d = StScale;
                    w_cnt_d   = '0;
                end
            end
            StScale: begin
                w_state_d = StConvert;
                w_cnt_d   = '0;
            end
            StConvert: begin
                w_cnt_d = '0;
                if (w_conv_done) w_state_d = StDone;
            end
            StDone: begin
                w_state_d = StGap;
                w_cnt_d   = '0;
            end
            StGap: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_d = StStart;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StStart;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state and registered, so they track r_state exactly.
    always_comb begin
        w_cs_n_d = 1'b1;
        w_wr_n_d = 1'b1;
        w_rd_n_d = 1'b1;
        case (w_state_d)
            StStart: begin
                w_cs_n_d = 1'b0;
                w_wr_n_d = 1'b0;
            end
            StWaitIntr: w_cs_n_d = 1'b0;
            StRead: begin
                w_cs_n_d = 1'b0;
                w_rd_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StStart;
            r_cnt         <= '0;
            r_intr_meta   <= 1'b1;
            r_intr_sync   <= 1'b1;
            r_data        <= '0;
            r_adc_cs_n    <= 1'b1;
            r_adc_wr_n    <= 1'b1;
            r_adc_rd_n    <= 1'b1;
            r_bcd         <= '0;
            r_bcd_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_intr_meta <= adc_intr_n;
            r_intr_sync <= r_intr_meta;
            r_adc_cs_n  <= w_cs_n_d;
            r_adc_wr_n  <= w_wr_n_d;
            r_adc_rd_n  <= w_rd_n_d;
            r_bcd_valid <= (w_state_d == StDone);
            if (r_state == StRead && w_state_d == StScale) r_data <= adc_data;
            if (w_state_d == StDone) r_bcd <= w_conv_bcd;
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (w_state_d == StDone) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign adc_cs_n    = r_adc_cs_n;
    assign adc_wr_n    = r_adc_wr_n;
    assign adc_rd_n    = r_adc_rd_n;
    assign bcd         = r_bcd;
    assign bcd_valid   = r_bcd_valid;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc0804_temp_bcd.sv
// Directed bench: two instances (100 and 50 centi-degrees per LSB) driven by a simple ADC model.
module tb_adc0804_temp_bcd;

    localparam int unsigned WR  = 4;
    localparam int unsigned RD  = 4;
    localparam int unsigned TO  = 60;
    localparam int unsigned GAP = 30;
    // intr driven at a sample point: two synchroniser edges, then RD_CYCLES+16 to the pulse
    localparam int unsigned LAT = 2 + RD + 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0][7:0] adc_data = '0;
    logic [1:0]      intr_n = 2'b11;
    logic [1:0]      cs_n, wr_n, rd_n, valid, terr;
    logic [1:0][15:0] bcd;
    logic [1:0]      prev_valid = 2'b00;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc0804_temp_bcd #(
        .WR_CYCLES(WR), .RD_CYCLES(RD), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CENTI_PER_LSB(100)
    ) u_dut100 (
        .clk(clk), .rst(rst), .adc_data(adc_data[0]), .adc_intr_n(intr_n[0]),
        .adc_cs_n(cs_n[0]), .adc_wr_n(wr_n[0]), .adc_rd_n(rd_n[0]),
        .bcd(bcd[0]), .bcd_valid(valid[0]), .timeout_err(terr[0])
    );

    adc0804_temp_bcd #(
        .WR_CYCLES(WR), .RD_CYCLES(RD), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CENTI_PER_LSB(50)
    ) u_dut50 (
        .clk(clk), .rst(rst), .adc_data(adc_data[1]), .adc_intr_n(intr_n[1]),
        .adc_cs_n(cs_n[1]), .adc_wr_n(wr_n[1]), .adc_rd_n(rd_n[1]),
        .bcd(bcd[1]), .bcd_valid(valid[1]), .timeout_err(terr[1])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Protocol rules on both instances, every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                assert (!(wr_n[d] === 1'b0 && rd_n[d] === 1'b0) &&
                        !(rd_n[d] === 1'b0 && cs_n[d] !== 1'b0) &&
                        !(valid[d] === 1'b1 && prev_valid[d] === 1'b1)) else begin
                    n_err++;
                    $error("FAIL protocol dut%0d observed wr=%b rd=%b cs=%b v=%b pv=%b expected legal",
                           d, wr_n[d], rd_n[d], cs_n[d], valid[d], prev_valid[d]);
                end
            end
        end
        prev_valid <= rst ? 2'b00 : valid;
    end

    task automatic measure_wr(input int d, input string tag);
        int w;
        w = 0;
        while (wr_n[d] === 1'b0 && w < 50) begin
            w++;
            @(posedge clk); #1;
        end
        chk({tag, "_wr_width"}, 16'(w), 16'(WR));
    endtask

    task automatic wait_wr_window(input int d, input string tag);
        int k;
        k = 0;
        while (wr_n[d] !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        while (wr_n[d] !== 1'b0 && k < 400) begin @(posedge clk); #1; k++; end
        chk({tag, "_start_seen"}, 16'(wr_n[d]), 16'h0000);
        measure_wr(d, tag);
    endtask

    // Called at the sample point where wr_n has just risen (instance now in WAIT_INTR).
    task automatic sample_from_wait(input int d, input logic [7:0] data, input logic [15:0] exp,
                                    input logic terr_before, input string tag);
        int n;
        int r;
        repeat (20) @(posedge clk);
        #1;
        chk({tag, "_terr_pre"}, 16'(terr[d]), 16'(terr_before));
        adc_data[d] = data;
        intr_n[d]   = 1'b0;
        n = 0;
        r = 0;
        while (valid[d] !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (rd_n[d] === 1'b0) r++;
        end
        chk({tag, "_latency"}, 16'(n), 16'(LAT));
        chk({tag, "_rd_width"}, 16'(r), 16'(RD));
        chk({tag, "_bcd"}, bcd[d], exp);
        chk({tag, "_terr_post"}, 16'(terr[d]), 16'h0000);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, 16'(valid[d]), 16'h0000);
        intr_n[d] = 1'b1;
    endtask

    task automatic do_sample(input int d, input logic [7:0] data, input logic [15:0] exp,
                             input logic terr_before, input string tag);
        wait_wr_window(d, tag);
        sample_from_wait(d, data, exp, terr_before, tag);
    endtask

    initial begin
        int n;
        int g;
        int bad;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_cs_n", 16'(cs_n[d]), 16'h0001);
            chk("rst_wr_n", 16'(wr_n[d]), 16'h0001);
            chk("rst_rd_n", 16'(rd_n[d]), 16'h0001);
            chk("rst_bcd", bcd[d], 16'h0000);
            chk("rst_valid", 16'(valid[d]), 16'h0000);
            chk("rst_terr", 16'(terr[d]), 16'h0000);
        end
        rst = 1'b0;

        do_sample(0, 8'h19, 16'h2500, 1'b0, "nom25");
        do_sample(0, 8'hFF, 16'h9999, 1'b0, "sat255");
        do_sample(0, 8'd99, 16'h9900, 1'b0, "edge99");

        // Timeout with intr held high, then a one-cycle intr glitch inside the gap.
        wait_wr_window(0, "to");
        n = 0;
        bad = 0;
        while (terr[0] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (valid[0] === 1'b1) bad++;
        end
        chk("to_cycles", 16'(n), 16'(TO));
        chk("to_no_valid", 16'(bad), 16'h0000);
        chk("to_bcd_held", bcd[0], 16'h9900);
        g = 0;
        bad = 0;
        while (wr_n[0] !== 1'b0 && g < 100) begin
            @(posedge clk); #1;
            g++;
            if (g == 5) intr_n[0] = 1'b0;
            if (g == 6) intr_n[0] = 1'b1;
            if (rd_n[0] === 1'b0 || valid[0] === 1'b1) bad++;
        end
        chk("gap_cycles", 16'(g), 16'(GAP));
        chk("gap_glitch_ignored", 16'(bad), 16'h0000);
        chk("gap_bcd_held", bcd[0], 16'h9900);
        measure_wr(0, "after_to");
        sample_from_wait(0, 8'd30, 16'h3000, 1'b1, "after_to");

        // Let one window time out, then reset in the middle of the next conversion.
        wait_wr_window(0, "rst_a");
        wait_wr_window(0, "rst_b");
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_terr_pre", 16'(terr[0]), 16'h0001);
        adc_data[0] = 8'd51;
        intr_n[0]   = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_bcd_pre", bcd[0], 16'h3000);
        rst       = 1'b1;
        intr_n[0] = 1'b1;
        #1;
        chk("rst_mid_cs_n", 16'(cs_n[0]), 16'h0001);
        chk("rst_mid_wr_n", 16'(wr_n[0]), 16'h0001);
        chk("rst_mid_rd_n", 16'(rd_n[0]), 16'h0001);
        chk("rst_mid_bcd", bcd[0], 16'h0000);
        chk("rst_mid_valid", 16'(valid[0]), 16'h0000);
        chk("rst_mid_terr", 16'(terr[0]), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_sample(0, 8'd7, 16'h0700, 1'b0, "post_rst");

        // Second instance has been timing out all along.
        do_sample(1, 8'd51, 16'h2550, 1'b1, "c50_frac");
        do_sample(1, 8'd0, 16'h0000, 1'b0, "c50_zero");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/adc0804_temp_bcd.md
Name: adc0804_temp_bcd

Overview:
Upstream feeder of the LCD display controller. Runs an ADC0804 free-running sample loop via its active-low CS/WR/RD/INTR handshake. Scales each 8-bit LM35 reading to hundredths of a degree C. Converts the scaled value to 4-digit packed BCD (XX.XX) and presents it on bcd[15:0] with a one-cycle valid strobe.

Parameters:
WR_CYCLES, 4, clk cycles adc_wr_n is held low to start a conversion (min 1)
RD_CYCLES, 4, clk cycles adc_rd_n is held low; data sampled on the last one (min 1)
TIMEOUT_CYCLES, 50000, max cycles to wait for adc_intr_n low before aborting
GAP_CYCLES, 100000, idle cycles between the end of one sample and the next start (min 1)
CENTI_PER_LSB, 100, hundredths of a degree C per ADC LSB (range 1..127)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
adc_data  in  8  ADC0804 DB7..DB0
adc_intr_n  in  1  ADC end-of-conversion, active low, asynchronous to clk
adc_cs_n  out  1  ADC chip select, active low
adc_wr_n  out  1  ADC start-conversion strobe, active low
adc_rd_n  out  1  ADC output enable, active low
bcd  out  16  packed BCD {tens, units, tenths, hundredths}
bcd_valid  out  1  one-cycle pulse when bcd updates
timeout_err  out  1  set on INTR timeout, cleared on next successful sample

Behaviour:
- Reset (async, any state): adc_cs_n=1, adc_wr_n=1, adc_rd_n=1, bcd=16'h0000, bcd_valid=0, timeout_err=0, FSM=START, all counters=0. The first START cycle begins on the first clk edge after rst deasserts.
- adc_intr_n passes through a 2-flop synchroniser (reset value 1) before any use.
- FSM states:
  - START: cs_n=0, wr_n=0 for exactly WR_CYCLES cycles, then -> WAIT_INTR.
  - WAIT_INTR: cs_n=0, wr_n=1, rd_n=1. Counts cycles.
    - Synced intr low -> READ.
    - Count reaches TIMEOUT_CYCLES -> set timeout_err, go to GAP. bcd is untouched and no valid pulse is issued.
  - READ: cs_n=0, rd_n=0 for exactly RD_CYCLES cycles. adc_data is captured on the last READ cycle, then -> SCALE.
  - SCALE (1 cycle): cs_n=1, rd_n=1.
    - prod = captured × CENTI_PER_LSB (15-bit unsigned).
    - If prod > 9999, saturate to 9999.
    - Result is a 14-bit value.
    - -> CONVERT.
  - CONVERT: sequential double-dabble, one shift per cycle, exactly 14 cycles. Add-3 applies to any nibble ≥5 before each shift. -> DONE.
  - DONE (1 cycle): register bcd, pulse bcd_valid=1, clear timeout_err. -> GAP.
  - GAP: all ADC strobes high. After GAP_CYCLES cycles -> START.
- Latency: bcd_valid fires exactly RD_CYCLES+16 cycles after the WAIT_INTR cycle that sees synced intr low.
- bcd holds its last value between updates. bcd_valid is never high for two consecutive cycles.
- adc_wr_n and adc_rd_n are never low in the same cycle. adc_rd_n is low only while adc_cs_n is low.
- intr already low on entry to WAIT_INTR is accepted immediately (no edge detection required).
- Glitches on adc_intr_n during READ/SCALE/CONVERT/GAP are ignored.
- All outputs are registered (no combinational paths from inputs).

Decomposition:
- Shared package (lcd_temp_pkg): FSM state enum, BCD_DIGITS=4, BCD_W=16, SAT_MAX=9999, BIN_W=14.
- The LCD controller imports the same BCD width constants.
- One sub-module, bin2bcd_seq. Interface: start, bin[13:0] -> busy, done, bcd[15:0]. Fixed 14-cycle latency; it implements the CONVERT state.

Test Plan:
- Reset: assert rst mid-CONVERT -> all outputs return to reset values the same cycle. After release, wr_n goes low for exactly WR_CYCLES=4 cycles.
- Nominal, CENTI=100: model drives intr_n low 20 cycles after wr_n rises, data=8'h19 (25) -> bcd=16'h2500, one bcd_valid pulse at the specified latency, timeout_err=0.
- Fractional, CENTI=50: data=8'd51 -> bcd=16'h2550. Also check data=8'd0 -> bcd=16'h0000 with valid pulse.
- Saturation, CENTI=100: data=8'hFF -> bcd=16'h9999. Also data=8'd99 -> 16'h9900 (boundary, no saturation).
- Timeout: intr_n held high -> timeout_err=1 after TIMEOUT_CYCLES, bcd unchanged, no valid pulse, next START after GAP_CYCLES. Next good sample (data=8'd30) -> bcd=16'h3000 and timeout_err cleared.
- Protocol checker (all runs): wr_n/rd_n never both low, rd_n low only with cs_n low, bcd_valid single-cycle, intr glitch during GAP has no effect.
